sr_pq_gen: RTL and testbench
============================

// Module: sr_pq_gen
// PURPOSE
//   Parametrised shift-register priority queue, successor to the fixed pq_pkg
//   shift-register PQ. Adds configurable key/value widths, depth and min/max
//   ordering, per-stage valid bits (the full key range is usable, no KEYINF
//   sentinel), an occupancy count, synchronous flush and error pulses. Drops
//   into the HWPQ study as a single-cycle enqueue/dequeue/replace queue.
// PARAMETERS
//   KEY_W      8   key width in bits
//   VAL_W      8   value width in bits
//   DEPTH      16  number of stages (>=2)
//   MAX_FIRST  0   0: smallest key at head; 1: largest key at head
// PORTS
//   clk        in   1                    clock; all state updates on rising edge
//   rst        in   1                    asynchronous, active-low reset
//   flush      in   1                    synchronous clear of all entries
//   enq        in   1                    enqueue request for kvi_key/kvi_value
//   deq        in   1                    dequeue request (removes head)
//   kvi_key    in   KEY_W                key to enqueue
//   kvi_value  in   VAL_W                value to enqueue
//   kvo_key    out  KEY_W                head key (stage 0)
//   kvo_value  out  VAL_W                head value (stage 0)
//   kvo_valid  out  1                    head entry is valid
//   full       out  1                    all DEPTH stages valid
//   empty      out  1                    no valid stage
//   count      out  $clog2(DEPTH+1)      number of valid entries
//   ovf        out  1                    1-cycle pulse: enqueue dropped (full)
//   udf        out  1                    1-cycle pulse: dequeue on empty
// BEHAVIOUR
//   - Reset (rst=0, async): all valid bits 0, keys/values 0; count=0, empty=1,
//     full=0, kvo_valid=0, kvo_key=0, kvo_value=0, ovf=0, udf=0.
//   - Storage: stage i holds {v[i],k[i],d[i]}; valid entries contiguous from
//     stage 0, sorted by priority. "Better" = strictly less (MAX_FIRST=0) or
//     strictly greater (MAX_FIRST=1). kvo_* driven from stage-0 registers.
//   - Latency: one cycle; an op issued in cycle N is visible on kvo_*/count
//     in cycle N+1. Queue is always ready (no busy, no stall).
//   - Enqueue only (enq & !deq & !full): insert at first stage j where v[j]=0
//     or kvi_key better than k[j]; stages >=j shift one toward tail. Equal keys
//     keep FIFO order (new entry goes after existing equals). count+1.
//   - Dequeue only (deq & !enq & !empty): every stage takes its successor;
//     last stage becomes invalid. count-1.
//   - Replace (enq & deq & !empty): head removed and new entry inserted in the
//     same cycle; permitted when full; count unchanged. Each stage selects from
//     {successor, kvi, self} via neighbour comparisons.
//   - enq & !deq & full: no state change; ovf=1 next cycle.
//   - deq & empty: udf=1 next cycle; if enq also set it acts as enqueue only.
//   - flush: highest priority over enq/deq; clears all valid bits, count=0,
//     no ovf/udf. Payload registers need not be cleared.
//   - ovf/udf registered, high exactly one cycle per offending request.
//   - Reset asserted mid-operation: in-flight op discarded, reset state wins.
//   - Invalid stages: kvo_key/kvo_value are don't-care when kvo_valid=0.
// CONFIGURATION
//   PQ_STATS_EN defined: adds outputs hwm [$clog2(DEPTH+1)] (max count since
//     reset/flush) and drop_cnt [16] (saturating count of ovf pulses); both
//     reset to 0 and clear on flush.
//   PQ_STATS_EN undefined: those ports and registers do not exist.
// TESTING (DEPTH=4, KEY_W=8, VAL_W=8 unless noted)
//   1 Reset: assert rst=0 mid-run -> count=0, empty=1, kvo_valid=0, ovf=udf=0.
//   2 Enq (5,A)(3,B)(9,C)(3,D) -> order 3B,3D,5A,9C; full=1, count=4, head 3/B.
//   3 Then enq (1,E) -> dropped, ovf=1 one cycle, contents unchanged;
//     with PQ_STATS_EN: drop_cnt=1, hwm=4.
//   4 Then enq+deq (4,F) -> 3D,4F,5A,9C; count=4, full=1, no ovf.
//   5 Deq x5 -> heads 3D,4F,5A,9C in turn, 5th cycle udf=1, empty=1;
//     then flush with enq -> count=0, no ovf/udf.
//   6 MAX_FIRST=1: enq 5,3,9 -> head 9, count=3; deq -> head 5.

Source files
------------

// File: rtl/sr_pq_gen.sv
// Purpose : parametrised shift-register priority queue (enqueue / dequeue / replace, min- or max-first).
// Latency : 1 cycle; an op issued in cycle N is visible on kvo_*/count/full/empty in cycle N+1.
// Backpr. : none, always ready; dropped enqueue pulses ovf, dequeue on empty pulses udf.
//
// Ports:
//   clk, rst (async active-low), flush (sync clear, overrides enq/deq)
//   enq/deq + kvi_key/kvi_value         : request and entry to insert
//   kvo_key/kvo_value/kvo_valid         : head entry (stage 0 registers)
//   full, empty, count                  : occupancy
//   ovf, udf                            : registered one-cycle error pulses
//   hwm, drop_cnt                       : only when PQ_STATS_EN is defined
//                                         (peak count, saturating drop count)
module sr_pq_gen #(
  parameter int KEY_W     = 8,
  parameter int VAL_W     = 8,
  parameter int DEPTH     = 16,
  parameter int MAX_FIRST = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         enq,
  input  logic                         deq,
  input  logic [KEY_W-1:0]             kvi_key,
  input  logic [VAL_W-1:0]             kvi_value,
  output logic [KEY_W-1:0]             kvo_key,
  output logic [VAL_W-1:0]             kvo_value,
  output logic                         kvo_valid,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         ovf,
  output logic                         udf
`ifdef PQ_STATS_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0]   hwm,
  output logic [15:0]                  drop_cnt
`endif
);

  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] ONE = 1;

  logic [DEPTH-1:0] v, nv;
  logic [KEY_W-1:0] k  [DEPTH];
  logic [KEY_W-1:0] nk [DEPTH];
  logic [VAL_W-1:0] d  [DEPTH];
  logic [VAL_W-1:0] nd [DEPTH];

  // ins[j]: new key belongs at or before stage j. Monotonic because valid
  // entries are sorted and contiguous; ins[DEPTH] models the slot past the tail.
  logic [DEPTH:0]   ins;
  logic [DEPTH-1:0] pos;

  logic do_enq, do_deq, do_rep, ovf_set, udf_set;
  logic [CW-1:0] count_nxt;

  function automatic logic better(input logic [KEY_W-1:0] a, input logic [KEY_W-1:0] b);
    if (MAX_FIRST != 0) return a > b;
    else                return a < b;
  endfunction

  assign full      = v[DEPTH-1];
  assign empty     = ~v[0];
  assign kvo_valid = v[0];
  assign kvo_key   = k[0];
  assign kvo_value = d[0];

  // Enqueue on empty with deq also set behaves as a plain enqueue.
  assign do_enq  = enq & ~full & (~deq | empty);
  assign do_rep  = enq & deq & ~empty;
  assign do_deq  = deq & ~enq & ~empty;
  assign ovf_set = enq & ~deq & full;
  assign udf_set = deq & empty;

  always_comb begin
    count_nxt = count;
    if (do_enq)      count_nxt = count + ONE;
    else if (do_deq) count_nxt = count - ONE;
  end

  assign ins[DEPTH] = 1'b1;

  for (genvar j = 0; j < DEPTH; j++) begin : g_stage
    logic             pos_prev, sel_ins, sel_prv, sel_suc;
    logic             pv, sv;
    logic [KEY_W-1:0] pk, sk;
    logic [VAL_W-1:0] pd, sd;

    // Strict comparison puts a new key after existing equal keys (FIFO among equals).
    assign ins[j] = ~v[j] | better(kvi_key, k[j]);
    // Replace inserts into the queue as it looks after the head is removed,
    // i.e. stage j compares against its successor.
    assign pos[j] = do_rep ? ins[j+1] : ins[j];

    if (j == 0) begin : g_head
      assign pos_prev = 1'b0;
      assign pv = 1'b0;
      assign pk = '0;
      assign pd = '0;
    end else begin : g_mid
      assign pos_prev = pos[j-1];
      assign pv = v[j-1];
      assign pk = k[j-1];
      assign pd = d[j-1];
    end

    if (j == DEPTH-1) begin : g_tail
      assign sv = 1'b0;
      assign sk = '0;
      assign sd = '0;
    end else begin : g_body
      assign sv = v[j+1];
      assign sk = k[j+1];
      assign sd = d[j+1];
    end

    assign sel_ins = (do_enq | do_rep) & pos[j] & ~pos_prev;
    assign sel_prv = do_enq & pos_prev;
    // In replace, stages ahead of the insertion point move up one; stages
    // behind it keep their own entry (the shift and the insert cancel out).
    assign sel_suc = do_deq | (do_rep & ~pos[j]);

    assign nv[j] = sel_ins ? 1'b1      : sel_prv ? pv : sel_suc ? sv : v[j];
    assign nk[j] = sel_ins ? kvi_key   : sel_prv ? pk : sel_suc ? sk : k[j];
    assign nd[j] = sel_ins ? kvi_value : sel_prv ? pd : sel_suc ? sd : d[j];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v     <= '0;
      count <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        k[i] <= '0;
        d[i] <= '0;
      end
    end else begin
      // Payload always follows the network; only the valid bits define content.
      for (int i = 0; i < DEPTH; i++) begin
        k[i] <= nk[i];
        d[i] <= nd[i];
      end
      if (flush) begin
        v     <= '0;
        count <= '0;
        ovf   <= 1'b0;
        udf   <= 1'b0;
      end else begin
        v     <= nv;
        count <= count_nxt;
        ovf   <= ovf_set;
        udf   <= udf_set;
      end
    end
  end

`ifdef PQ_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hwm      <= '0;
      drop_cnt <= '0;
    end else if (flush) begin
      hwm      <= '0;
      drop_cnt <= '0;
    end else begin
      if (count_nxt > hwm) hwm <= count_nxt;
      if (ovf_set && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sr_pq_gen.sv
// Bench for sr_pq_gen: table of {inputs, expected next-cycle outputs} applied
// through a scoreboard queue, plus hand sequences for async reset and max-first.
module tb_sr_pq_gen;

  logic       clk = 1'b0;
  logic       rst, flush, enq, deq;
  logic [7:0] kvi_key, kvi_value, kvo_key, kvo_value;
  logic       kvo_valid, full, empty, ovf, udf;
  logic [2:0] count;

  logic       m_flush, m_enq, m_deq;
  logic [7:0] m_key, m_val, m_okey, m_oval;
  logic       m_ovalid, m_full, m_empty, m_ovf, m_udf;
  logic [2:0] m_count;

`ifdef PQ_STATS_EN
  logic [2:0]  hwm, m_hwm;
  logic [15:0] drop_cnt, m_drop;
`endif

  always #5 clk = ~clk;

  sr_pq_gen #(.KEY_W(8), .VAL_W(8), .DEPTH(4), .MAX_FIRST(0)) dut (
    .clk(clk), .rst(rst), .flush(flush), .enq(enq), .deq(deq),
    .kvi_key(kvi_key), .kvi_value(kvi_value),
    .kvo_key(kvo_key), .kvo_value(kvo_value), .kvo_valid(kvo_valid),
    .full(full), .empty(empty), .count(count), .ovf(ovf), .udf(udf)
`ifdef PQ_STATS_EN
    , .hwm(hwm), .drop_cnt(drop_cnt)
`endif
  );

  sr_pq_gen #(.KEY_W(8), .VAL_W(8), .DEPTH(4), .MAX_FIRST(1)) dut_max (
    .clk(clk), .rst(rst), .flush(m_flush), .enq(m_enq), .deq(m_deq),
    .kvi_key(m_key), .kvi_value(m_val),
    .kvo_key(m_okey), .kvo_value(m_oval), .kvo_valid(m_ovalid),
    .full(m_full), .empty(m_empty), .count(m_count), .ovf(m_ovf), .udf(m_udf)
`ifdef PQ_STATS_EN
    , .hwm(m_hwm), .drop_cnt(m_drop)
`endif
  );

  typedef struct {
    logic        fl, en, de;
    logic [7:0]  key, val;
    logic        ev;
    logic [7:0]  ek, ed;
    logic [2:0]  ec;
    logic        ef, ee, eo, eu;
    logic [2:0]  eh;
    logic [15:0] edc;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic fl, en, de, input logic [7:0] key, val,
                     input logic ev, input logic [7:0] ek, ed, input logic [2:0] ec,
                     input logic ef, ee, eo, eu, input logic [2:0] eh, input logic [15:0] edc);
    vec_t r;
    r.fl = fl; r.en = en; r.de = de; r.key = key; r.val = val;
    r.ev = ev; r.ek = ek; r.ed = ed; r.ec = ec;
    r.ef = ef; r.ee = ee; r.eo = eo; r.eu = eu; r.eh = eh; r.edc = edc;
    vecs.push_back(r);
  endtask

  task automatic check_outputs(input int i, input vec_t e);
    chk($sformatf("v%0d_valid", i), kvo_valid, e.ev);
    if (e.ev) begin
      chk($sformatf("v%0d_key", i), kvo_key, e.ek);
      chk($sformatf("v%0d_value", i), kvo_value, e.ed);
    end
    chk($sformatf("v%0d_count", i), count, e.ec);
    chk($sformatf("v%0d_full", i), full, e.ef);
    chk($sformatf("v%0d_empty", i), empty, e.ee);
    chk($sformatf("v%0d_ovf", i), ovf, e.eo);
    chk($sformatf("v%0d_udf", i), udf, e.eu);
`ifdef PQ_STATS_EN
    chk($sformatf("v%0d_hwm", i), hwm, e.eh);
    chk($sformatf("v%0d_drop_cnt", i), drop_cnt, e.edc);
`endif
  endtask

  initial begin
    vec_t e;
    rst = 1'b0; flush = 1'b0; enq = 1'b0; deq = 1'b0; kvi_key = '0; kvi_value = '0;
    m_flush = 1'b0; m_enq = 1'b0; m_deq = 1'b0; m_key = '0; m_val = '0;

    //  fl en de key    val     ev ek     ed     cnt f  e  o  u  hwm drop
    add(0, 1, 0, 8'd5,  8'h0A,  1, 8'd5,  8'h0A, 1,  0, 0, 0, 0, 1,  0);
    add(0, 1, 0, 8'd3,  8'h0B,  1, 8'd3,  8'h0B, 2,  0, 0, 0, 0, 2,  0);
    add(0, 1, 0, 8'd9,  8'h0C,  1, 8'd3,  8'h0B, 3,  0, 0, 0, 0, 3,  0);
    add(0, 1, 0, 8'd3,  8'h0D,  1, 8'd3,  8'h0B, 4,  1, 0, 0, 0, 4,  0);
    add(0, 1, 0, 8'd1,  8'h0E,  1, 8'd3,  8'h0B, 4,  1, 0, 1, 0, 4,  1);
    add(0, 0, 0, 8'd0,  8'h00,  1, 8'd3,  8'h0B, 4,  1, 0, 0, 0, 4,  1);
    add(0, 1, 1, 8'd4,  8'h0F,  1, 8'd3,  8'h0D, 4,  1, 0, 0, 0, 4,  1);
    add(0, 0, 1, 8'd0,  8'h00,  1, 8'd4,  8'h0F, 3,  0, 0, 0, 0, 4,  1);
    add(0, 0, 1, 8'd0,  8'h00,  1, 8'd5,  8'h0A, 2,  0, 0, 0, 0, 4,  1);
    add(0, 0, 1, 8'd0,  8'h00,  1, 8'd9,  8'h0C, 1,  0, 0, 0, 0, 4,  1);
    add(0, 0, 1, 8'd0,  8'h00,  0, 8'd0,  8'h00, 0,  0, 1, 0, 0, 4,  1);
    add(0, 0, 1, 8'd0,  8'h00,  0, 8'd0,  8'h00, 0,  0, 1, 0, 1, 4,  1);
    add(0, 0, 0, 8'd0,  8'h00,  0, 8'd0,  8'h00, 0,  0, 1, 0, 0, 4,  1);
    add(1, 1, 0, 8'd7,  8'h07,  0, 8'd0,  8'h00, 0,  0, 1, 0, 0, 0,  0);
    add(0, 1, 1, 8'd6,  8'h10,  1, 8'd6,  8'h10, 1,  0, 0, 0, 1, 1,  0);
    add(0, 1, 0, 8'd6,  8'h11,  1, 8'd6,  8'h10, 2,  0, 0, 0, 0, 2,  0);
    add(0, 0, 1, 8'd0,  8'h00,  1, 8'd6,  8'h11, 1,  0, 0, 0, 0, 2,  0);
    add(0, 1, 0, 8'd2,  8'h01,  1, 8'd2,  8'h01, 2,  0, 0, 0, 0, 2,  0);
    add(0, 1, 0, 8'd8,  8'h02,  1, 8'd2,  8'h01, 3,  0, 0, 0, 0, 3,  0);
    add(0, 1, 0, 8'd7,  8'h03,  1, 8'd2,  8'h01, 4,  1, 0, 0, 0, 4,  0);
    add(0, 1, 1, 8'hC8, 8'h04,  1, 8'd6,  8'h11, 4,  1, 0, 0, 0, 4,  0);
    add(0, 0, 1, 8'd0,  8'h00,  1, 8'd7,  8'h03, 3,  0, 0, 0, 0, 4,  0);
    add(0, 0, 1, 8'd0,  8'h00,  1, 8'd8,  8'h02, 2,  0, 0, 0, 0, 4,  0);
    add(0, 1, 0, 8'd1,  8'h05,  1, 8'd1,  8'h05, 3,  0, 0, 0, 0, 4,  0);
    add(0, 1, 0, 8'd9,  8'h06,  1, 8'd1,  8'h05, 4,  1, 0, 0, 0, 4,  0);
    add(1, 1, 0, 8'd3,  8'h07,  0, 8'd0,  8'h00, 0,  0, 1, 0, 0, 0,  0);
    add(0, 0, 0, 8'd0,  8'h00,  0, 8'd0,  8'h00, 0,  0, 1, 0, 0, 0,  0);

    // Reset state
    #12;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_valid", kvo_valid, 0);
    chk("rst_key", kvo_key, 0);
    chk("rst_value", kvo_value, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_udf", udf, 0);
    @(negedge clk); rst = 1'b1;

    // Table through the scoreboard
    foreach (vecs[i]) begin
      @(negedge clk);
      flush = vecs[i].fl; enq = vecs[i].en; deq = vecs[i].de;
      kvi_key = vecs[i].key; kvi_value = vecs[i].val;
      exp_q.push_back(vecs[i]);
      @(posedge clk); #1;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_empty got 0 expected 1 entry");
      end else begin
        e = exp_q.pop_front();
        check_outputs(i, e);
      end
    end
    chk("sb_drained", exp_q.size(), 0);

    // Async reset asserted mid-cycle with an enqueue pending
    @(negedge clk); flush = 1'b0; deq = 1'b0; enq = 1'b1; kvi_key = 8'd4; kvi_value = 8'h44;
    @(posedge clk); #1;
    chk("pre_rst_count", count, 1);
    @(negedge clk); kvi_key = 8'd5;
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_valid", kvo_valid, 0);
    chk("mid_rst_key", kvo_key, 0);
    chk("mid_rst_ovf", ovf, 0);
    chk("mid_rst_udf", udf, 0);
    @(posedge clk); #1;
    chk("held_rst_count", count, 0);
    @(negedge clk); rst = 1'b1; enq = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_empty", empty, 1);

    // Max-first ordering
    @(negedge clk); m_enq = 1'b1; m_key = 8'd5; m_val = 8'h50;
    @(negedge clk); m_key = 8'd3; m_val = 8'h30;
    @(negedge clk); m_key = 8'd9; m_val = 8'h90;
    @(negedge clk); m_enq = 1'b0;
    chk("max_head_key", m_okey, 9);
    chk("max_head_val", m_oval, 8'h90);
    chk("max_count", m_count, 3);
    m_deq = 1'b1;
    @(negedge clk); m_deq = 1'b0;
    chk("max_deq_key", m_okey, 5);
    chk("max_deq_count", m_count, 2);
    chk("max_udf", m_udf, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
